// File: rtl/cpu64_l1_miss_ctrl.sv
// L1 miss controller: picks a PLRU victim, optionally releases it, acquires the refill, updates metadata.
// Build option: define CPU64_L1_CLEAN_RELEASE_EN to also issue Release for valid clean victims.
module cpu64_l1_miss_ctrl #(
    parameter int unsigned INDEX_W = 5,
    parameter int unsigned TAG_W   = 20
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               miss_valid_i,
    output logic               miss_ready_o,
    input  logic [INDEX_W-1:0] miss_set_i,
    input  logic [TAG_W-1:0]   miss_tag_i,
    input  logic [2:0]         victim_i,
    input  logic               vic_valid_i,
    input  logic               vic_dirty_i,
    input  logic [TAG_W-1:0]   vic_tag_i,
    output logic [INDEX_W-1:0] plru_set_o,
    output logic               plru_access_o,
    output logic [2:0]         plru_way_o,
    output logic               wb_valid_o,
    input  logic               wb_ready_i,
    output logic [INDEX_W-1:0] wb_set_o,
    output logic [TAG_W-1:0]   wb_tag_o,
    output logic [2:0]         wb_way_o,
    output logic               wb_dirty_o,
    output logic               acq_valid_o,
    input  logic               acq_ready_i,
    output logic [INDEX_W-1:0] acq_set_o,
    output logic [TAG_W-1:0]   acq_tag_o,
    output logic [2:0]         acq_way_o,
    input  logic               grant_done_i,
    output logic               meta_we_o,
    output logic [INDEX_W-1:0] meta_set_o,
    output logic [2:0]         meta_way_o,
    output logic [TAG_W-1:0]   meta_tag_o,
    output logic               busy_o,
    output logic               done_o
);

    localparam int unsigned WAY_W = 3;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SELECT     = 3'd1,
        WB_REQ     = 3'd2,
        ACQ_REQ    = 3'd3,
        WAIT_GRANT = 3'd4,
        UPDATE     = 3'd5
    } state_e;

    state_e             state_q;
    logic [INDEX_W-1:0] set_q;
    logic [TAG_W-1:0]   tag_q;
    logic [TAG_W-1:0]   vtag_q;
    logic [WAY_W-1:0]   way_q;
    logic               dirty_q;
    logic               need_wb;

`ifdef CPU64_L1_CLEAN_RELEASE_EN
    assign need_wb = vic_valid_i;
`else
    assign need_wb = vic_valid_i && vic_dirty_i;
`endif

    // Control FSM; every strobe is set on entry to the state that owns it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            set_q         <= '0;
            tag_q         <= '0;
            vtag_q        <= '0;
            way_q         <= '0;
            dirty_q       <= 1'b0;
            miss_ready_o  <= 1'b1;
            busy_o        <= 1'b0;
            wb_valid_o    <= 1'b0;
            acq_valid_o   <= 1'b0;
            meta_we_o     <= 1'b0;
            plru_access_o <= 1'b0;
            done_o        <= 1'b0;
        end else begin
            meta_we_o     <= 1'b0;
            plru_access_o <= 1'b0;
            done_o        <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (miss_valid_i) begin
                        set_q        <= miss_set_i;
                        tag_q        <= miss_tag_i;
                        miss_ready_o <= 1'b0;
                        busy_o       <= 1'b1;
                        state_q      <= SELECT;
                    end
                end
                SELECT: begin
                    way_q   <= victim_i;
                    vtag_q  <= vic_tag_i;
                    dirty_q <= vic_dirty_i;
                    if (need_wb) begin
                        wb_valid_o <= 1'b1;
                        state_q    <= WB_REQ;
                    end else begin
                        acq_valid_o <= 1'b1;
                        state_q     <= ACQ_REQ;
                    end
                end
                WB_REQ: begin
                    if (wb_ready_i) begin
                        wb_valid_o  <= 1'b0;
                        acq_valid_o <= 1'b1;
                        state_q     <= ACQ_REQ;
                    end
                end
                ACQ_REQ: begin
                    if (acq_ready_i) begin
                        acq_valid_o <= 1'b0;
                        state_q     <= WAIT_GRANT;
                    end
                end
                WAIT_GRANT: begin
                    if (grant_done_i) begin
                        meta_we_o     <= 1'b1;
                        plru_access_o <= 1'b1;
                        done_o        <= 1'b1;
                        state_q       <= UPDATE;
                    end
                end
                UPDATE: begin
                    miss_ready_o <= 1'b1;
                    busy_o       <= 1'b0;
                    state_q      <= IDLE;
                end
                default: begin
                    miss_ready_o <= 1'b1;
                    busy_o       <= 1'b0;
                    wb_valid_o   <= 1'b0;
                    acq_valid_o  <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    // PLRU lookup follows the incoming request until a miss is captured.
    assign plru_set_o = (state_q == IDLE) ? miss_set_i : set_q;
    assign plru_way_o = way_q;

    assign wb_set_o   = set_q;
    assign wb_tag_o   = vtag_q;
    assign wb_way_o   = way_q;
    assign wb_dirty_o = dirty_q;

    assign acq_set_o  = set_q;
    assign acq_tag_o  = tag_q;
    assign acq_way_o  = way_q;

    assign meta_set_o = set_q;
    assign meta_way_o = way_q;
    assign meta_tag_o = tag_q;

endmodule

// File: doc/cpu64_l1_miss_ctrl.md
CPU64_L1_MISS_CTRL -- requirements
Module: cpu64_l1_miss_ctrl

Interface
REQ-001 SHALL have parameter INDEX_W, default 5: set index width.
REQ-002 SHALL have parameter TAG_W, default 20: line tag width.
REQ-003 SHALL have port clk_i  input  1: sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst_ni  input  1: reset, asynchronous assert, active-low.
REQ-005 SHALL have ports miss_valid_i input 1, miss_ready_o output 1, miss_set_i input INDEX_W, miss_tag_i input TAG_W: miss request from the lookup stage.
REQ-006 SHALL have ports victim_i input 3, vic_valid_i input 1, vic_dirty_i input 1, vic_tag_i input TAG_W: PLRU victim way and metadata of that way for set plru_set_o.
REQ-007 SHALL have ports plru_set_o output INDEX_W, plru_access_o output 1, plru_way_o output 3: drive the PLRU set select and update.
REQ-008 SHALL have ports wb_valid_o output 1, wb_ready_i input 1, wb_set_o output INDEX_W, wb_tag_o output TAG_W, wb_way_o output 3, wb_dirty_o output 1: eviction (Release) request.
REQ-009 SHALL have ports acq_valid_o output 1, acq_ready_i input 1, acq_set_o output INDEX_W, acq_tag_o output TAG_W, acq_way_o output 3: refill (Acquire) request.
REQ-010 SHALL have port grant_done_i input 1: single-cycle pulse, refill data fully written.
REQ-011 SHALL have ports meta_we_o output 1, meta_set_o output INDEX_W, meta_way_o output 3, meta_tag_o output TAG_W: metadata write (valid=1, dirty=0).
REQ-012 SHALL have ports busy_o output 1 (state != IDLE) and done_o output 1 (one-cycle completion pulse).

Function
REQ-013 SHALL implement FSM states IDLE, SELECT, WB_REQ, ACQ_REQ, WAIT_GRANT, UPDATE.
REQ-014 IDLE: miss_ready_o=1; on miss_valid_i capture set/tag, go SELECT; all other states miss_ready_o=0.
REQ-015 plru_set_o SHALL equal miss_set_i in IDLE, captured set in every other state.
REQ-016 SELECT (exactly one cycle): latch victim_i, vic_valid_i, vic_dirty_i, vic_tag_i; go WB_REQ if need_wb, else ACQ_REQ.
REQ-017 need_wb SHALL be vic_valid_i && vic_dirty_i (see REQ-029 for macro variant).
REQ-018 WB_REQ: wb_valid_o=1 with latched set/tag/way, wb_dirty_o=latched dirty; payload stable until wb_ready_i; on wb_valid_o&&wb_ready_i go ACQ_REQ.
REQ-019 ACQ_REQ: acq_valid_o=1 with captured set, miss tag, latched way; stable until acq_ready_i; on handshake go WAIT_GRANT.
REQ-020 WAIT_GRANT: on grant_done_i go UPDATE; grant_done_i in any other state SHALL be ignored.
REQ-021 UPDATE (exactly one cycle): meta_we_o=1, plru_access_o=1, done_o=1, way outputs = latched way, meta_tag_o = miss tag; then IDLE.
REQ-022 New miss SHALL NOT be accepted in the UPDATE cycle; earliest acceptance is the following IDLE cycle.
REQ-023 Minimum latency, no writeback, readies high, immediate grant: accept at cycle N, done_o at N+4.
REQ-024 wb_valid_o, acq_valid_o, meta_we_o, plru_access_o, done_o SHALL be 0 outside their stated states.

Reset
REQ-025 On rst_ni low, FSM SHALL enter IDLE immediately, regardless of current state, including mid-handshake.
REQ-026 Reset values: all valid/strobe outputs 0, busy_o 0, miss_ready_o 1 once rst_ni high, latched registers 0.
REQ-027 An in-flight miss aborted by reset SHALL produce no meta_we_o, plru_access_o or done_o.

Configuration
REQ-028 Macro CPU64_L1_CLEAN_RELEASE_EN SHALL select clean-eviction behaviour.
REQ-029 Defined: need_wb = vic_valid_i (valid clean victims also issue Release, wb_dirty_o=0); undefined: need_wb = vic_valid_i && vic_dirty_i, clean victims silently dropped.

Verification
REQ-030 Invalid victim: miss set=3 tag=0x00ABC, victim_i=5 vic_valid_i=0, readies high, grant next cycle -> no wb_valid_o, acq way=5 set=3 tag=0x00ABC, meta_we_o/plru_access_o way=5 and done_o at accept+4.
REQ-031 Dirty victim: set=7, victim_i=2 valid=1 dirty=1 tag=0x12345, wb_ready_i held low 3 cycles -> wb_valid_o high 4 cycles with wb_tag_o=0x12345 wb_dirty_o=1 stable, then acq_valid_o.
REQ-032 Clean valid victim way 6: macro undefined -> no wb_valid_o; macro defined -> one Release with wb_dirty_o=0, wb_way_o=6.
REQ-033 grant_done_i pulsed during ACQ_REQ (acq_ready_i low) -> ignored, FSM remains in ACQ_REQ and then waits in WAIT_GRANT for a later pulse.
REQ-034 rst_ni asserted during WAIT_GRANT -> busy_o 0 asynchronously, no done_o/meta_we_o; next miss after release completes normally.
REQ-035 Back-to-back misses with miss_valid_i held high -> second accepted the cycle after UPDATE, miss_ready_o 0 during UPDATE.
